muldiv_unit: RTL and testbench

Parametrised, multi-cycle integer multiply/divide unit. It supersedes the single-cycle combinational `*`, `/` and `%` paths of the pipeline ALU. The unit implements signed and unsigned multiply (shift-add, one bit per cycle) and signed and unsigned divide (restoring, one bit per cycle), writing a double-width HI/LO result. It sits beside the ALU in the EX stage; the pipeline stalls on `md_busy` and captures HI/LO on `md_done`.

---
 rtl/muldiv_unit.sv | 258 +++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle integer multiply/divide unit for the EX stage. Multiply is
// shift-add and divide is restoring, each retiring one bit per cycle. Both work
// on operand magnitudes, and the sign is applied in a final fix-up cycle. The
// result is a double-width HI/LO pair.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   md_start     request, sampled only while idle
//   md_op        00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div
//   md_a         multiplicand / dividend (sampled with md_start)
//   md_b         multiplier / divisor (sampled with md_start)
//   md_flush     synchronous abort of any operation in flight
//   md_busy      high while an operation is in flight
//   md_done      one-cycle completion pulse; md_hi/md_lo are updated with it
//   md_hi        mul: upper product half, div: remainder
//   md_lo        mul: lower product half, div: quotient
//   md_div_zero  qualifies md_done; set when a divide had a zero divisor
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] md_a,
    input  logic [WIDTH-1:0] md_b,
    input  logic             md_flush,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] md_hi,
    output logic [WIDTH-1:0] md_lo,
    output logic             md_div_zero
);

    localparam int unsigned    CntW     = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } state_e;

    // State and datapath registers
    state_e               r_state;
    logic                 r_is_div;     // signedness is folded into the magnitudes
    logic [WIDTH-1:0]     r_mag_a;      // multiplicand magnitude
    logic [WIDTH-1:0]     r_mag_b;      // divisor magnitude
    logic [2*WIDTH-1:0]   r_acc;        // mul: product/multiplier, div: {rem, quo}
    logic [CntW-1:0]      r_cnt;
    logic                 r_neg_prod;   // sign of product / quotient
    logic                 r_neg_rem;    // sign of remainder
    logic                 r_dz_pend;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic                 r_div_zero;

    // Next-state values
    state_e               w_state_next;
    logic                 w_is_div_next;
    logic [WIDTH-1:0]     w_mag_a_next;
    logic [WIDTH-1:0]     w_mag_b_next;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [CntW-1:0]      w_cnt_next;
    logic                 w_neg_prod_next;
    logic                 w_neg_rem_next;
    logic                 w_dz_pend_next;
    logic [WIDTH-1:0]     w_hi_next;
    logic [WIDTH-1:0]     w_lo_next;
    logic                 w_done_next;
    logic                 w_div_zero_next;

    // Operand preparation (idle only)
    logic                 w_signed;
    logic                 w_sign_a;
    logic                 w_sign_b;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic                 w_b_zero;

    // Iteration datapath
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_acc;
    logic [WIDTH:0]       w_div_rem_sh;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_div_acc;

    // Sign fix-up
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    // -------------------------------------------------------------------------
    // Operand preparation
    // -------------------------------------------------------------------------
    assign w_signed = ~md_op[0];
    assign w_sign_a = w_signed & md_a[WIDTH-1];
    assign w_sign_b = w_signed & md_b[WIDTH-1];
    // MIN maps onto itself, which reads correctly as the unsigned magnitude.
    assign w_abs_a  = w_sign_a ? (~md_a + 1'b1) : md_a;
    assign w_abs_b  = w_sign_b ? (~md_b + 1'b1) : md_b;
    assign w_b_zero = (md_b == '0);

    // -------------------------------------------------------------------------
    // Multiply step: add multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
    // The extra sum bit holds the carry and becomes the new MSB.
    // -------------------------------------------------------------------------
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_mag_a} : {(WIDTH+1){1'b0}});
    assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

    // -------------------------------------------------------------------------
    // Divide step: the shifted remainder needs WIDTH+1 bits; a set MSB in the
    // trial difference means the subtraction borrowed and is discarded.
    // -------------------------------------------------------------------------
    assign w_div_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff   = w_div_rem_sh - {1'b0, r_mag_b};
    assign w_div_acc    = w_div_diff[WIDTH]
                        ? {w_div_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                        : {w_div_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

    // -------------------------------------------------------------------------
    // Sign fix-up applied in FIX
    // -------------------------------------------------------------------------
    assign w_prod_fix = r_neg_prod ? (~r_acc + 1'b1) : r_acc;
    assign w_quo_fix  = r_neg_prod ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_rem  ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                                   : r_acc[2*WIDTH-1:WIDTH];

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_is_div_next   = r_is_div;
        w_mag_a_next    = r_mag_a;
        w_mag_b_next    = r_mag_b;
        w_acc_next      = r_acc;
        w_cnt_next      = r_cnt;
        w_neg_prod_next = r_neg_prod;
        w_neg_rem_next  = r_neg_rem;
        w_dz_pend_next  = r_dz_pend;
        w_hi_next       = r_hi;
        w_lo_next       = r_lo;
        w_done_next     = 1'b0;
        w_div_zero_next = r_div_zero;

        if (md_flush) begin
            // Abort wins over everything, including a same-cycle start.
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (md_start) begin
                        w_is_div_next   = md_op[1];
                        w_mag_a_next    = w_abs_a;
                        w_mag_b_next    = w_abs_b;
                        w_neg_prod_next = w_sign_a ^ w_sign_b;
                        w_neg_rem_next  = w_sign_a;
                        w_cnt_next      = '0;
                        if (md_op[1] && w_b_zero) begin
                            // Preload the divide-by-zero result so FIX just copies it.
                            w_acc_next     = {md_a, {WIDTH{1'b1}}};
                            w_dz_pend_next = 1'b1;
                            w_state_next   = StFix;
                        end else begin
                            w_acc_next     = {{WIDTH{1'b0}}, (md_op[1] ? w_abs_a : w_abs_b)};
                            w_dz_pend_next = 1'b0;
                            w_state_next   = StCalc;
                        end
                    end
                end

                StCalc: begin
                    w_acc_next = r_is_div ? w_div_acc : w_mul_acc;
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == LastIter) begin
                        w_state_next = StFix;
                    end
                end

                StFix: begin
                    if (r_dz_pend) begin
                        w_hi_next       = r_acc[2*WIDTH-1:WIDTH];
                        w_lo_next       = r_acc[WIDTH-1:0];
                        w_div_zero_next = 1'b1;
                    end else if (r_is_div) begin
                        w_hi_next       = w_rem_fix;
                        w_lo_next       = w_quo_fix;
                        w_div_zero_next = 1'b0;
                    end else begin
                        w_hi_next       = w_prod_fix[2*WIDTH-1:WIDTH];
                        w_lo_next       = w_prod_fix[WIDTH-1:0];
                        w_div_zero_next = 1'b0;
                    end
                    w_done_next  = 1'b1;
                    w_state_next = StIdle;
                end

                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_is_div   <= 1'b0;
            r_mag_a    <= '0;
            r_mag_b    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_neg_prod <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_dz_pend  <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_is_div   <= w_is_div_next;
            r_mag_a    <= w_mag_a_next;
            r_mag_b    <= w_mag_b_next;
            r_acc      <= w_acc_next;
            r_cnt      <= w_cnt_next;
            r_neg_prod <= w_neg_prod_next;
            r_neg_rem  <= w_neg_rem_next;
            r_dz_pend  <= w_dz_pend_next;
            r_hi       <= w_hi_next;
            r_lo       <= w_lo_next;
            r_done     <= w_done_next;
            r_div_zero <= w_div_zero_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign md_busy     = (r_state != StIdle);
    assign md_done     = r_done;
    assign md_hi       = r_hi;
    assign md_lo       = r_lo;
    assign md_div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Self-checking bench for muldiv_unit at WIDTH = 32. Results are compared
// against a reference model built on 64-bit integer arithmetic.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         md_start = 1'b0;
    logic [1:0]   md_op = 2'b00;
    logic [W-1:0] md_a = '0;
    logic [W-1:0] md_b = '0;
    logic         md_flush = 1'b0;
    logic         md_busy;
    logic         md_done;
    logic [W-1:0] md_hi;
    logic [W-1:0] md_lo;
    logic         md_div_zero;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(
        .WIDTH(W)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .md_start   (md_start),
        .md_op      (md_op),
        .md_a       (md_a),
        .md_b       (md_b),
        .md_flush   (md_flush),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .md_hi      (md_hi),
        .md_lo      (md_lo),
        .md_div_zero(md_div_zero)
    );

    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic. SV division truncates toward
    // zero and the remainder takes the dividend's sign, matching the unit.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] hi,
                                  output logic [W-1:0] lo, output logic dz);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        dz = 1'b0;
        hi = '0;
        lo = '0;
        if (op[1] && b == 0) begin
            hi = a;
            lo = '1;
            dz = 1'b1;
        end else begin
            case (op)
                2'b00:   p = longint'(sa * sb);
                2'b01:   p = ua * ub;
                2'b10:   p = {longint'(sa % sb), 32'd0} | {32'd0, 32'(sa / sb)};
                default: p = {(ua % ub), 32'd0} | {32'd0, 32'(ua / ub)};
            endcase
            hi = p[63:32];
            lo = p[31:0];
        end
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic [W-1:0] b);
        return (op[1] && b == 0) ? 1 : W + 1;
    endfunction

    // Issue one operation and wait (bounded) for its completion. With now=1
    // the request is driven immediately, e.g. in a done cycle.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit now, output logic [W-1:0] hi, output logic [W-1:0] lo,
                         output logic dz, output int lat, output int busy_cnt,
                         output logic busy_at_done, output bit timed_out);
        if (!now) @(negedge clk);
        md_op = op;
        md_a = a;
        md_b = b;
        md_start = 1'b1;
        lat = 0;
        busy_cnt = 0;
        timed_out = 1'b1;
        hi = '0;
        lo = '0;
        dz = 1'b0;
        busy_at_done = 1'b1;
        @(posedge clk);
        #1;
        md_start = 1'b0;
        while (timed_out && lat < 100) begin
            if (md_busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
            if (md_done) begin
                timed_out = 1'b0;
                hi = md_hi;
                lo = md_lo;
                dz = md_div_zero;
                busy_at_done = md_busy;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({md_busy, md_done, md_div_zero} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got %b want 000", {md_busy, md_done, md_div_zero});
        end
        checks++;
        if ({md_hi, md_lo} !== 64'd0) begin
            failures++;
            $display("FAIL reset_hilo: got %h_%h want 0_0", md_hi, md_lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({md_busy, md_done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release: busy/done got %b want 00", {md_busy, md_done});
        end
    endtask

    task automatic test_mul_unsigned();
        logic [W-1:0] hi, lo, eh, el;
        logic dz, ed, bad;
        int lat, bc;
        bit to;
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, hi, lo, dz, lat, bc, bad, to);
        checks++;
        if (to || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            failures++;
            $display("FAIL mulu_max: got %h_%h timeout=%0d want fffffffe_00000001", hi, lo, to);
        end
        checks++;
        if (lat !== 33 || bc !== 33 || bad !== 1'b0) begin
            failures++;
            $display("FAIL mulu_timing: lat=%0d busy=%0d busy_at_done=%b want 33/33/0",
                     lat, bc, bad);
        end
        for (int i = 0; i < 15; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = (i % 5 == 0) ? W'($urandom_range(0, 3)) : $urandom;
            model(2'b01, a, b, eh, el, ed);
            do_op(2'b01, a, b, 1'b0, hi, lo, dz, lat, bc, bad, to);
            checks++;
            if (to || hi !== eh || lo !== el || dz !== ed) begin
                failures++;
                $display("FAIL mulu_rand a=%h b=%h: got %h_%h dz=%b want %h_%h dz=%b",
                         a, b, hi, lo, dz, eh, el, ed);
            end
        end
    endtask

    task automatic test_mul_signed();
        logic [W-1:0] hi, lo, eh, el;
        logic dz, ed, bad;
        int lat, bc;
        bit to;
        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, hi, lo, dz, lat, bc, bad, to);
        checks++;
        if (to || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB || lat !== 33) begin
            failures++;
            $display("FAIL muls_m3x7: got %h_%h lat=%0d want ffffffff_ffffffeb lat=33",
                     hi, lo, lat);
        end
        for (int i = 0; i < 15; i++) begin
            logic [W-1:0] a, b;
            a = (i == 0) ? 32'h8000_0000 : $urandom;
            b = (i == 1) ? 32'h8000_0000 : $urandom;
            model(2'b00, a, b, eh, el, ed);
            do_op(2'b00, a, b, 1'b0, hi, lo, dz, lat, bc, bad, to);
            checks++;
            if (to || hi !== eh || lo !== el || dz !== ed) begin
                failures++;
                $display("FAIL muls_rand a=%h b=%h: got %h_%h dz=%b want %h_%h dz=%b",
                         a, b, hi, lo, dz, eh, el, ed);
            end
        end
    endtask

    task automatic test_div();
        logic [W-1:0] hi, lo, eh, el;
        logic dz, ed, bad;
        int lat, bc;
        bit to;
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, hi, lo, dz, lat, bc, bad, to);
        checks++;
        if (to || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || dz !== 1'b0) begin
            failures++;
            $display("FAIL divs_m7d2: got hi=%h lo=%h dz=%b want ffffffff fffffffd 0",
                     hi, lo, dz);
        end
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] a, b;
            logic [1:0] op;
            op = (i % 2 == 0) ? 2'b10 : 2'b11;
            a = $urandom;
            case (i % 6)
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = $urandom >> $urandom_range(0, 31);
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            model(op, a, b, eh, el, ed);
            do_op(op, a, b, 1'b0, hi, lo, dz, lat, bc, bad, to);
            checks++;
            if (to || hi !== eh || lo !== el || dz !== ed || lat !== exp_latency(op, b)) begin
                failures++;
                $display("FAIL div_rand op=%b a=%h b=%h: got %h_%h dz=%b lat=%0d want %h_%h dz=%b",
                         op, a, b, hi, lo, dz, lat, eh, el, ed);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] hi, lo;
        logic dz, bad;
        int lat, bc;
        bit to;
        do_op(2'b11, 32'd100, 32'd0, 1'b0, hi, lo, dz, lat, bc, bad, to);
        checks++;
        if (to || dz !== 1'b1 || lo !== 32'hFFFF_FFFF || hi !== 32'h0000_0064) begin
            failures++;
            $display("FAIL divz_u: got hi=%h lo=%h dz=%b want 00000064 ffffffff 1", hi, lo, dz);
        end
        checks++;
        if (lat !== 1 || bc !== 1) begin
            failures++;
            $display("FAIL divz_timing: lat=%0d busy=%0d want 1/1", lat, bc);
        end
        do_op(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, hi, lo, dz, lat, bc, bad, to);
        checks++;
        if (to || dz !== 1'b1 || lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FF00) begin
            failures++;
            $display("FAIL divz_s: got hi=%h lo=%h dz=%b want ffffff00 ffffffff 1", hi, lo, dz);
        end
        // A later non-zero divide must clear the flag again.
        do_op(2'b11, 32'd9, 32'd4, 1'b0, hi, lo, dz, lat, bc, bad, to);
        checks++;
        if (to || dz !== 1'b0 || lo !== 32'd2 || hi !== 32'd1) begin
            failures++;
            $display("FAIL divz_clear: got hi=%h lo=%h dz=%b want 1 2 0", hi, lo, dz);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] hi, lo;
        logic dz, bad;
        int lat, bc;
        bit to;
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, hi, lo, dz, lat, bc, bad, to);
        // Still inside the done cycle: start the next op with no bubble.
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, hi, lo, dz, lat, bc, bad, to);
        checks++;
        if (to || lo !== 32'h8000_0000 || hi !== 32'd0 || dz !== 1'b0) begin
            failures++;
            $display("FAIL b2b_minneg1: got hi=%h lo=%h dz=%b want 0 80000000 0", hi, lo, dz);
        end
        checks++;
        if (lat !== 33 || bc !== 33) begin
            failures++;
            $display("FAIL b2b_timing: lat=%0d busy=%0d want 33/33", lat, bc);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] hi, lo;
        logic dz, bad;
        int lat, bc, seen;
        bit to;
        do_op(2'b01, 32'd2, 32'h8000_0001, 1'b0, hi, lo, dz, lat, bc, bad, to);
        checks++;
        if (to || hi !== 32'd1 || lo !== 32'd2) begin
            failures++;
            $display("FAIL flush_prior: got %h_%h want 00000001_00000002", hi, lo);
        end
        @(negedge clk);
        md_op = 2'b01;
        md_a = 32'd5;
        md_b = 32'd6;
        md_start = 1'b1;
        @(posedge clk);
        #1;
        md_start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        md_flush = 1'b1;
        md_start = 1'b1;
        @(posedge clk);
        #1;
        md_flush = 1'b0;
        md_start = 1'b0;
        checks++;
        if (md_busy !== 1'b0 || md_done !== 1'b0 || md_hi !== 32'd1 || md_lo !== 32'd2) begin
            failures++;
            $display("FAIL flush_abort: busy=%b done=%b hi=%h lo=%h want 0 0 1 2",
                     md_busy, md_done, md_hi, md_lo);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (md_done || md_busy) seen++;
        end
        checks++;
        if (seen !== 0 || md_hi !== 32'd1 || md_lo !== 32'd2 || md_div_zero !== 1'b0) begin
            failures++;
            $display("FAIL flush_quiet: activity=%0d hi=%h lo=%h want 0 1 2", seen, md_hi, md_lo);
        end
        do_op(2'b01, 32'd5, 32'd6, 1'b0, hi, lo, dz, lat, bc, bad, to);
        checks++;
        if (to || lo !== 32'd30 || hi !== 32'd0 || lat !== 33) begin
            failures++;
            $display("FAIL flush_restart: got %h_%h lat=%0d want 0_1e lat=33", hi, lo, lat);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        md_op = 2'b10;
        md_a = 32'd1000;
        md_b = 32'd7;
        md_start = 1'b1;
        @(posedge clk);
        #1;
        md_start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({md_busy, md_done, md_div_zero} !== 3'b000 || {md_hi, md_lo} !== 64'd0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                     md_busy, md_done, md_div_zero, md_hi, md_lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (md_done || md_busy) seen++;
        end
        checks++;
        if (seen !== 0 || {md_hi, md_lo} !== 64'd0) begin
            failures++;
            $display("FAIL reset_mid_after: activity=%0d hi=%h lo=%h want 0 0 0",
                     seen, md_hi, md_lo);
        end
    endtask

    task automatic test_ignored_start();
        logic [W-1:0] eh, el;
        logic ed;
        int lat, extra;
        bit got;
        model(2'b01, 32'd1234567, 32'd89, eh, el, ed);
        @(negedge clk);
        md_op = 2'b01;
        md_a = 32'd1234567;
        md_b = 32'd89;
        md_start = 1'b1;
        @(posedge clk);
        #1;
        md_start = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            if (lat == 5) begin
                md_op = 2'b11;
                md_a = 32'd5;
                md_b = 32'd0;
                md_start = 1'b1;
            end
            @(posedge clk);
            #1;
            md_start = 1'b0;
            lat++;
            if (md_done) got = 1'b1;
        end
        checks++;
        if (!got || lat !== 33 || md_hi !== eh || md_lo !== el || md_div_zero !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start: done=%b lat=%0d hi=%h lo=%h dz=%b want 1 33 %h %h 0",
                     got, lat, md_hi, md_lo, md_div_zero, eh, el);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (md_done || md_busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL ignore_start_queued: activity=%0d want 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_mul_unsigned();
        test_mul_signed();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_ignored_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
